// File: rtl/metadata_extractor.sv
// AXI-Stream metadata extractor: buffers input beats in a small FIFO and, in extraction mode,
// strips each packet's first beat and overlays its timestamp/destination onto later beats' tuser.
module metadata_extractor #(
   parameter int C_S_AXIS_DATA_WIDTH   = 256,
   parameter int C_M_AXIS_DATA_WIDTH   = 256,
   parameter int C_S_AXIS_TUSER_WIDTH  = 128,
   parameter int C_M_AXIS_TUSER_WIDTH  = 128,
   parameter int C_TS_WIDTH            = 32,
   parameter int C_TUSER_TIMESTAMP_POS = 32,
   parameter int C_DST_WIDTH           = 8,
   parameter int C_TUSER_DST_POS       = 24,
   parameter int C_TS_FIRST_BEAT_ONLY  = 1,
   parameter int C_FIFO_DEPTH_BITS     = 2
) (
   input  logic                               axi_aclk,
   input  logic                               axi_aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic                               s_axis_tvalid,
   input  logic                               s_axis_tlast,
   output logic                               s_axis_tready,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
   output logic                               m_axis_tvalid,
   output logic                               m_axis_tlast,
   input  logic                               m_axis_tready,
   input  logic                               em_enable,
   input  logic                               sw_rst,
   output logic [31:0]                        pkt_count,
   output logic [31:0]                        drop_count
);
   localparam int DW    = C_S_AXIS_DATA_WIDTH;
   localparam int SW    = DW / 8;
   localparam int UW    = C_S_AXIS_TUSER_WIDTH;
   localparam int AW    = C_FIFO_DEPTH_BITS;
   localparam int DEPTH = 1 << AW;
   localparam int DSTW  = (C_DST_WIDTH > 0) ? C_DST_WIDTH : 1;
   localparam logic [0:0] HEAD = 1'b0;
   localparam logic [0:0] BODY = 1'b1;

   if (C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH) begin : g_err_dw
      $error("metadata_extractor: input and output data widths differ");
   end
   if (C_M_AXIS_TUSER_WIDTH != C_S_AXIS_TUSER_WIDTH) begin : g_err_uw
      $error("metadata_extractor: input and output tuser widths differ");
   end
   if ((DW % 8) != 0) begin : g_err_dw8
      $error("metadata_extractor: data width must be a multiple of 8");
   end
   if (C_TS_WIDTH != 32 && C_TS_WIDTH != 64) begin : g_err_ts
      $error("metadata_extractor: timestamp width must be 32 or 64");
   end
   if (C_DST_WIDTH < 0 || C_DST_WIDTH > 8) begin : g_err_dst
      $error("metadata_extractor: destination width must be 0..8");
   end
   if (C_FIFO_DEPTH_BITS < 1 || C_FIFO_DEPTH_BITS > 5) begin : g_err_depth
      $error("metadata_extractor: FIFO depth bits must be 1..5");
   end
   if (C_TS_WIDTH + C_DST_WIDTH > DW) begin : g_err_meta
      $error("metadata_extractor: metadata fields exceed data width");
   end
   if (C_TUSER_TIMESTAMP_POS < 0 || C_TUSER_TIMESTAMP_POS + C_TS_WIDTH > UW) begin : g_err_tspos
      $error("metadata_extractor: timestamp overlay outside tuser");
   end
   if (C_DST_WIDTH > 0 && (C_TUSER_DST_POS < 0 || C_TUSER_DST_POS + C_DST_WIDTH > UW)) begin : g_err_dstpos
      $error("metadata_extractor: destination overlay outside tuser");
   end

   logic [DW-1:0]     fifo_data_q [DEPTH];
   logic [SW-1:0]     fifo_strb_q [DEPTH];
   logic [UW-1:0]     fifo_user_q [DEPTH];
   logic              fifo_last_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [1:0]        rst_sync_q, rst_sync_d;
   logic [0:0]        state_q, state_d;
   logic              mode_q, mode_d, first_q, first_d;
   logic [C_TS_WIDTH-1:0] ts_q, ts_d, ts_field;
   logic [DSTW-1:0]   dst_q, dst_d, head_dst;
   logic [31:0]       pkt_q, pkt_d, drop_q, drop_d;
   logic              push, pop, empty;
   logic [DW-1:0]     head_data;
   logic [UW-1:0]     head_user;
   logic              head_last;

   function automatic logic [UW-1:0] apply_overlay(input logic [UW-1:0] user,
                                                   input logic [C_TS_WIDTH-1:0] ts,
                                                   input logic [DSTW-1:0] dst);
      logic [UW-1:0] r;
      r = user;
      for (int i = 0; i < C_TS_WIDTH; i++) r[C_TUSER_TIMESTAMP_POS + i] = ts[i];
      for (int i = 0; i < C_DST_WIDTH; i++) r[C_TUSER_DST_POS + i] = dst[i];
      return r;
   endfunction

   assign head_data = fifo_data_q[rd_ptr_q];
   assign head_user = fifo_user_q[rd_ptr_q];
   assign head_last = fifo_last_q[rd_ptr_q];

   if (C_DST_WIDTH > 0) begin : g_dst
      assign head_dst = head_data[C_TS_WIDTH +: DSTW];
   end else begin : g_no_dst
      assign head_dst = '0;
   end

   assign m_axis_tdata  = head_data;
   assign m_axis_tstrb  = fifo_strb_q[rd_ptr_q];
   assign m_axis_tlast  = head_last;
   assign pkt_count     = pkt_q;
   assign drop_count    = drop_q;
   // Ready depends only on registered occupancy and the reset synchroniser, never on m_axis_tready.
   assign s_axis_tready = rst_sync_q[1] & ~sw_rst & ~count_q[AW];
   assign push          = s_axis_tvalid & s_axis_tready;
   assign empty         = (count_q == '0);
   assign ts_field      = (first_q || C_TS_FIRST_BEAT_ONLY == 0) ? ts_q : '0;
   assign rst_sync_d    = {rst_sync_q[0], 1'b1};

   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      first_d       = first_q;
      ts_d          = ts_q;
      dst_d         = dst_q;
      pkt_d         = pkt_q;
      drop_d        = drop_q;
      pop           = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tuser  = head_user;
      if (!empty && !sw_rst) begin
         if (state_q == HEAD) begin
            mode_d = em_enable;
            if (em_enable) begin
               pop     = 1'b1;
               ts_d    = head_data[C_TS_WIDTH-1:0];
               dst_d   = head_dst;
               first_d = 1'b1;
               if (head_last) drop_d  = drop_q + 32'd1;
               else           state_d = BODY;
            end else begin
               m_axis_tvalid = 1'b1;
               if (m_axis_tready) begin
                  pop = 1'b1;
                  if (head_last) pkt_d   = pkt_q + 32'd1;
                  else           state_d = BODY;
               end
            end
         end else begin
            m_axis_tvalid = 1'b1;
            if (mode_q) m_axis_tuser = apply_overlay(head_user, ts_field, dst_q);
            if (m_axis_tready) begin
               pop     = 1'b1;
               first_d = 1'b0;
               if (head_last) begin
                  pkt_d   = pkt_q + 32'd1;
                  state_d = HEAD;
               end
            end
         end
      end
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (!push && pop) count_d = count_q - (AW+1)'(1);
      if (sw_rst) begin
         state_d  = HEAD;
         mode_d   = 1'b0;
         first_d  = 1'b0;
         ts_d     = '0;
         dst_d    = '0;
         pkt_d    = '0;
         drop_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= s_axis_tdata;
         fifo_strb_q[wr_ptr_q] <= s_axis_tstrb;
         fifo_user_q[wr_ptr_q] <= s_axis_tuser;
         fifo_last_q[wr_ptr_q] <= s_axis_tlast;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         rst_sync_q <= '0;
         state_q    <= HEAD;
         mode_q     <= 1'b0;
         first_q    <= 1'b0;
         ts_q       <= '0;
         dst_q      <= '0;
         pkt_q      <= '0;
         drop_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
         state_q    <= state_d;
         mode_q     <= mode_d;
         first_q    <= first_d;
         ts_q       <= ts_d;
         dst_q      <= dst_d;
         pkt_q      <= pkt_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end
endmodule

// File: tb/tb_metadata_extractor.sv
// Bench for metadata_extractor: packet-level reference model plus directed scenarios and random bursts.
module tb_metadata_extractor;
   typedef struct { logic [255:0] d; logic [31:0] s; logic [127:0] u; logic l; } beat_t;

   logic         axi_aclk = 1'b0;
   logic         axi_aresetn;
   logic [255:0] s_axis_tdata;
   logic [31:0]  s_axis_tstrb;
   logic [127:0] s_axis_tuser;
   logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tstrb;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic         em_enable, sw_rst;
   logic [31:0]  pkt_count, drop_count;

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 0;
   beat_t exp_q[$];
   beat_t obs_q[$];
   bit          m_head = 1'b1;
   bit          m_mode = 1'b0;
   bit          m_first = 1'b0;
   logic [31:0] m_ts = '0;
   logic [7:0]  m_dst = '0;
   logic [31:0] exp_pkt = '0;
   logic [31:0] exp_drop = '0;

   metadata_extractor dut (
      .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .em_enable(em_enable), .sw_rst(sw_rst), .pkt_count(pkt_count), .drop_count(drop_count)
   );

   initial forever #5 axi_aclk = ~axi_aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] rand_data();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference model: per-packet rules applied as each beat is accepted.
   task automatic model_beat(input beat_t b);
      beat_t o;
      o = b;
      if (m_head) begin
         m_mode = em_enable;
         if (m_mode) begin
            m_ts    = b.d[31:0];
            m_dst   = b.d[39:32];
            m_first = 1'b1;
            if (b.l) exp_drop = exp_drop + 32'd1;
            else     m_head = 1'b0;
         end else begin
            exp_q.push_back(o);
            if (b.l) exp_pkt = exp_pkt + 32'd1;
            else     m_head = 1'b0;
         end
      end else begin
         if (m_mode) begin
            o.u[63:32] = m_first ? m_ts : 32'd0;
            o.u[31:24] = m_dst;
            m_first = 1'b0;
         end
         exp_q.push_back(o);
         if (b.l) begin
            exp_pkt = exp_pkt + 32'd1;
            m_head  = 1'b1;
         end
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_head   = 1'b1;
      m_first  = 1'b0;
      exp_pkt  = '0;
      exp_drop = '0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the handshake.
   task automatic send(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u, input logic l);
      beat_t b;
      int    waitc;
      bit    ok;
      b.d = d; b.s = s; b.u = u; b.l = l;
      s_axis_tdata = d; s_axis_tstrb = s; s_axis_tuser = u; s_axis_tlast = l;
      s_axis_tvalid = 1'b1;
      waitc = 0; ok = 1'b0;
      while (!ok && waitc < 300) begin
         @(negedge axi_aclk);
         if (s_axis_tready) ok = 1'b1;
         else waitc++;
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: actual=no s_axis_tready required=ready within 300 cycles");
         s_axis_tvalid = 1'b0;
         return;
      end
      @(posedge axi_aclk); #1;
      s_axis_tvalid = 1'b0;
      model_beat(b);
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 500) begin
         @(negedge axi_aclk);
         c++;
      end
      chk("drain_pending", 256'(exp_q.size()), 256'(0));
      repeat (6) @(posedge axi_aclk);
      #1;
   endtask

   task automatic do_swrst();
      sw_rst = 1'b1;
      model_reset();
      @(posedge axi_aclk); #1;
      sw_rst = 1'b0;
      chk("swrst_pkt", 256'(pkt_count), 256'(0));
      chk("swrst_drop", 256'(drop_count), 256'(0));
   endtask

   task automatic set_stall(input bit on);
      rdy_mode      = on ? 2 : 0;
      m_axis_tready = !on;
   endtask

   // Output-ready driver.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge axi_aclk); #1;
         if (rdy_mode == 1)      m_axis_tready = ($urandom_range(0, 3) != 0);
         else if (rdy_mode == 2) m_axis_tready = 1'b0;
         else                    m_axis_tready = 1'b1;
      end
   end

   // Compare process: every handshake against the model, and hold-stability while stalled.
   initial begin
      beat_t a, e, prev;
      bit    prev_stall;
      prev_stall = 1'b0;
      forever begin
         @(negedge axi_aclk);
         a.d = m_axis_tdata; a.s = m_axis_tstrb; a.u = m_axis_tuser; a.l = m_axis_tlast;
         if (!axi_aresetn || sw_rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 256'(m_axis_tvalid), 256'(1));
               chk("hold_data", a.d, prev.d);
               chk("hold_user", 256'(a.u), 256'(prev.u));
               chk("hold_last", 256'(a.l), 256'(prev.l));
            end
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_beat: actual data=%0h required=no beat", a.d);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", a.d, e.d);
                  chk("out_strb", 256'(a.s), 256'(e.s));
                  chk("out_user", 256'(a.u), 256'(e.u));
                  chk("out_last", 256'(a.l), 256'(e.l));
               end
               obs_q.push_back(a);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev = a;
         end
      end
   end

   initial begin
      beat_t o;
      logic [255:0] d;
      int len;
      axi_aresetn = 1'b0; sw_rst = 1'b0; em_enable = 1'b0;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0;

      // Reset state and synchronised release.
      repeat (3) @(negedge axi_aclk);
      chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
      chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
      chk("rst_pkt", 256'(pkt_count), 256'(0));
      chk("rst_drop", 256'(drop_count), 256'(0));
      @(posedge axi_aclk); #1;
      axi_aresetn = 1'b1;
      @(negedge axi_aclk);
      chk("tready_edge0", 256'(s_axis_tready), 256'(0));
      @(negedge axi_aclk);
      chk("tready_edge1", 256'(s_axis_tready), 256'(0));
      @(negedge axi_aclk);
      chk("tready_edge2", 256'(s_axis_tready), 256'(1));
      @(posedge axi_aclk); #1;

      // Extraction, timestamp on first payload beat only.
      obs_q.delete();
      em_enable = 1'b1;
      send(256'h05_DEADBEEF, 32'hFFFF_FFFF, '1, 1'b0);
      send(256'hA1, 32'hFFFF_FFFF, '1, 1'b0);
      send(256'hA2, 32'h0000_000F, '1, 1'b1);
      drain();
      chk("ext_beats", 256'(obs_q.size()), 256'(2));
      o = obs_q[0];
      chk("ext_b1_user", 256'(o.u), 256'(128'hFFFFFFFF_FFFFFFFF_DEADBEEF_05FFFFFF));
      chk("ext_b1_data", o.d, 256'hA1);
      o = obs_q[1];
      chk("ext_b2_user", 256'(o.u), 256'(128'hFFFFFFFF_FFFFFFFF_00000000_05FFFFFF));
      chk("ext_pkt", 256'(pkt_count), 256'(1));

      // Bypass.
      do_swrst();
      obs_q.delete();
      em_enable = 1'b0;
      send(256'h1234_5678, 32'hFFFF_FFFF, 128'hABCD, 1'b0);
      send(256'h9ABC_DEF0, 32'h0000_00FF, 128'h5EED, 1'b1);
      drain();
      chk("byp_beats", 256'(obs_q.size()), 256'(2));
      o = obs_q[0];
      chk("byp_b0_data", o.d, 256'h1234_5678);
      chk("byp_b0_user", 256'(o.u), 256'(128'hABCD));
      o = obs_q[1];
      chk("byp_b1_user", 256'(o.u), 256'(128'h5EED));
      chk("byp_b1_strb", 256'(o.s), 256'(32'h0000_00FF));
      chk("byp_pkt", 256'(pkt_count), 256'(1));

      // em_enable toggled mid-packet: current packet keeps overlay, next is bypassed.
      do_swrst();
      obs_q.delete();
      em_enable = 1'b1;
      send(256'h7E_01020304, '1, '0, 1'b0);
      send(256'hB1, '1, '0, 1'b0);
      em_enable = 1'b0;
      send(256'hB2, '1, '0, 1'b0);
      send(256'hB3, '1, '0, 1'b1);
      send(256'hC0, '1, 128'h55, 1'b0);
      send(256'hC1, '1, 128'h66, 1'b1);
      drain();
      chk("tog_beats", 256'(obs_q.size()), 256'(5));
      o = obs_q[0];
      chk("tog_b1_user", 256'(o.u), 256'(128'h01020304_7E000000));
      o = obs_q[2];
      chk("tog_b3_user", 256'(o.u), 256'(128'h7E000000));
      o = obs_q[3];
      chk("tog_next_user", 256'(o.u), 256'(128'h55));
      chk("tog_pkt", 256'(pkt_count), 256'(2));

      // Backpressure with a full FIFO.
      do_swrst();
      obs_q.delete();
      em_enable = 1'b0;
      set_stall(1'b1);
      for (int i = 0; i < 4; i++) send(256'(16'h0100 + i), '1, 128'(i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge axi_aclk);
         chk("bp_s_tready", 256'(s_axis_tready), 256'(0));
         chk("bp_m_tvalid", 256'(m_axis_tvalid), 256'(1));
      end
      @(posedge axi_aclk); #1;
      set_stall(1'b0);
      send(256'h0104, '1, 128'h4, 1'b0);
      send(256'h0105, '1, 128'h5, 1'b1);
      drain();
      chk("bp_beats", 256'(obs_q.size()), 256'(6));
      for (int i = 0; i < 6; i++) begin
         o = obs_q[i];
         chk("bp_order", o.d, 256'(16'h0100 + i));
      end
      chk("bp_pkt", 256'(pkt_count), 256'(1));

      // Metadata-only packet, then a normal one.
      do_swrst();
      obs_q.delete();
      em_enable = 1'b1;
      send(256'h09_11223344, '1, '0, 1'b1);
      drain();
      chk("meta_only_drop", 256'(drop_count), 256'(1));
      chk("meta_only_beats", 256'(obs_q.size()), 256'(0));
      send(256'h0BADF00D, '1, '0, 1'b0);
      send(256'hD1, '1, '0, 1'b1);
      drain();
      chk("meta_next_beats", 256'(obs_q.size()), 256'(1));
      o = obs_q[0];
      chk("meta_next_ts", 256'(o.u[63:32]), 256'(32'h0BADF00D));
      chk("meta_next_pkt", 256'(pkt_count), 256'(1));

      // Soft reset with a partial packet buffered.
      obs_q.delete();
      em_enable = 1'b1;
      set_stall(1'b1);
      send(256'h01_AAAA5555, '1, '0, 1'b0);
      send(256'hE1, '1, '0, 1'b0);
      send(256'hE2, '1, '0, 1'b0);
      repeat (3) begin @(posedge axi_aclk); #1; end
      do_swrst();
      set_stall(1'b0);
      @(negedge axi_aclk);
      chk("swrst_empty_tready", 256'(s_axis_tready), 256'(1));
      chk("swrst_empty_tvalid", 256'(m_axis_tvalid), 256'(0));
      @(posedge axi_aclk); #1;
      send(256'h3C_CAFEF00D, '1, '0, 1'b0);
      send(256'hE3, '1, '1, 1'b1);
      drain();
      chk("swrst_beats", 256'(obs_q.size()), 256'(1));
      o = obs_q[0];
      chk("swrst_next_user", 256'(o.u), 256'(128'hFFFFFFFF_FFFFFFFF_CAFEF00D_3CFFFFFF));
      chk("swrst_next_pkt", 256'(pkt_count), 256'(1));

      // Asynchronous reset mid-packet.
      obs_q.delete();
      set_stall(1'b1);
      send(256'h02_0F0F0F0F, '1, '0, 1'b0);
      send(256'hF1, '1, '0, 1'b0);
      axi_aresetn = 1'b0;
      model_reset();
      #1;
      chk("arst_pkt", 256'(pkt_count), 256'(0));
      chk("arst_tvalid", 256'(m_axis_tvalid), 256'(0));
      chk("arst_tready", 256'(s_axis_tready), 256'(0));
      @(posedge axi_aclk); #1;
      axi_aresetn = 1'b1;
      set_stall(1'b0);
      send(256'h12345678, '1, '0, 1'b0);
      send(256'hF2, '1, '0, 1'b1);
      drain();
      chk("arst_beats", 256'(obs_q.size()), 256'(1));
      o = obs_q[0];
      chk("arst_next_ts", 256'(o.u[63:32]), 256'(32'h12345678));
      chk("arst_next_pkt", 256'(pkt_count), 256'(1));

      // Random bursts with random output backpressure.
      for (int burst = 0; burst < 8; burst++) begin
         em_enable = 1'($urandom_range(0, 1));
         rdy_mode  = 1;
         for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
               d = rand_data();
               send(d, $urandom, {$urandom, $urandom, $urandom, $urandom}, (b == len - 1));
               repeat ($urandom_range(0, 2)) begin @(posedge axi_aclk); #1; end
            end
         end
         drain();
         chk("rand_pkt", 256'(pkt_count), 256'(exp_pkt));
         chk("rand_drop", 256'(drop_count), 256'(exp_drop));
      end
      rdy_mode = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/metadata_extractor.md
METADATA_EXTRACTOR -- requirements
Module: metadata_extractor

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- C_S_AXIS_DATA_WIDTH, 256, input tdata width.
- C_M_AXIS_DATA_WIDTH, 256, output tdata width; SHALL equal input width.
- C_S_AXIS_TUSER_WIDTH / C_M_AXIS_TUSER_WIDTH, 128, tuser width; the two SHALL be equal.
- C_TS_WIDTH, 32, timestamp field width; legal values 32 or 64.
- C_TUSER_TIMESTAMP_POS, 32, tuser LSB where the timestamp is written.
- C_DST_WIDTH, 8, destination field width; legal values 0..8, where 0 disables the field.
- C_TUSER_DST_POS, 24, tuser LSB where the destination is written.
- C_TS_FIRST_BEAT_ONLY, 1, when 1 the timestamp goes on the first output beat only and later beats get zero in that field.
- C_FIFO_DEPTH_BITS, 2, input FIFO depth is 2**C_FIFO_DEPTH_BITS; legal values 1..5.

REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- axi_aclk, in, 1, the single clock; all logic runs on its rising edge.
- axi_aresetn, in, 1, reset, asynchronous, active-low.
- s_axis_tdata/tstrb/tuser/tvalid/tlast, in, DATA/DATA÷8/TUSER/1/1, input stream.
- s_axis_tready, out, 1, input stream ready.
- m_axis_tdata/tstrb/tuser/tvalid/tlast, out, DATA/DATA÷8/TUSER/1/1, output stream.
- m_axis_tready, in, 1, output stream ready.
- em_enable, in, 1, extraction mode request.
- sw_rst, in, 1, synchronous soft reset, active-high.
- pkt_count, out, 32, packets fully emitted on m_axis.
- drop_count, out, 32, packets consumed but not emitted.

Function
REQ-003 SHALL buffer every accepted input beat (tdata, tstrb, tuser, tlast) in an internal FIFO.
- s_axis_tready = (FIFO occupancy < depth), with no combinational path from m_axis_tready.
- A beat accepted in cycle N SHALL be presentable on m_axis no earlier than cycle N+1.

REQ-004 SHALL implement states HEAD and BODY; HEAD means the FIFO head is the first beat of a packet.

REQ-005 In HEAD with FIFO non-empty, SHALL sample em_enable into mode_r.
- mode_r governs the whole packet.
- em_enable changes during a packet SHALL have no effect until the next HEAD.

REQ-006 In HEAD with em_enable=1 (extraction mode):
- Pop the head beat without presenting it (m_axis_tvalid=0).
- Latch ts_r = tdata[C_TS_WIDTH-1:0] and dst_r = tdata[C_TS_WIDTH+C_DST_WIDTH-1:C_TS_WIDTH].
- If that beat has tlast=1: increment drop_count and remain in HEAD.
- Otherwise: go to BODY.
- Consumption SHALL take one cycle.

REQ-007 In HEAD with em_enable=0 (bypass mode):
- Present the head beat unmodified.
- On handshake, go to BODY if tlast=0.
- If tlast=1, stay in HEAD and increment pkt_count.

REQ-008 In BODY with FIFO non-empty, SHALL assert m_axis_tvalid with tdata, tstrb and tlast taken from the head beat.
- Pop only when m_axis_tvalid && m_axis_tready.
- tvalid and data SHALL stay stable while tready=0.

REQ-009 In BODY with mode_r=1, SHALL output tuser equal to the head tuser with these overlays:
- Bits [C_TUSER_TIMESTAMP_POS+C_TS_WIDTH-1:C_TUSER_TIMESTAMP_POS] = ts_r. After the first handshake of the packet this field is 0 if C_TS_FIRST_BEAT_ONLY=1, else ts_r.
- Bits [C_TUSER_DST_POS+C_DST_WIDTH-1:C_TUSER_DST_POS] = dst_r on every beat, when C_DST_WIDTH>0.
- All other tuser bits are passed through.

REQ-010 With mode_r=0, SHALL pass tuser through unmodified.

REQ-011 On a handshake with tlast=1 in BODY, SHALL increment pkt_count and go to HEAD.

REQ-012 With FIFO empty, SHALL hold m_axis_tvalid=0, the current state and all latched fields.

REQ-013 Simultaneous push and pop in the same cycle SHALL be supported.
- Occupancy is unchanged.
- A full FIFO popping in a cycle SHALL NOT accept input in that same cycle (tready is from registered occupancy).

REQ-014 Counters SHALL wrap modulo 2**32.
- pkt_count and drop_count increment by at most 1 per cycle each.

REQ-015 Parameter checks:
- ts and dst fields SHALL satisfy C_TS_WIDTH+C_DST_WIDTH <= C_S_AXIS_DATA_WIDTH.
- Overlay ranges SHALL lie within the tuser width.
- Illegal values SHALL stop elaboration.

Reset
REQ-016 axi_aresetn=0 SHALL asynchronously clear:
- state to HEAD;
- FIFO to empty;
- mode_r, ts_r, dst_r, pkt_count and drop_count to 0.
While reset is asserted, m_axis_tvalid=0 and s_axis_tready=0.

REQ-017 sw_rst=1 SHALL do the same clearing as REQ-016 on the next clock edge.
- Any partial packet is discarded without a counter increment.
- The first beat accepted after release is treated as a packet head.

REQ-018 Reset release SHALL be synchronised internally so that s_axis_tready rises no earlier than the second clock edge after deassertion.

Verification
REQ-019 Bench SHALL cover these scenarios:
- Extraction, C_TS_FIRST_BEAT_ONLY=1. Stimulus: em_enable=1; a 3-beat packet whose metadata beat is tdata[31:0]=0xDEADBEEF, tdata[39:32]=0x05. Response: 2 output beats; beat 1 tuser[63:32]=0xDEADBEEF and tuser[31:24]=0x05; beat 2 tuser[63:32]=0; pkt_count=1.
- Bypass. Stimulus: em_enable=0; a 2-beat packet. Response: 2 beats identical to the input; pkt_count=1.
- Mid-packet toggle. Stimulus: em_enable toggled 1→0 during the BODY of a 4-beat packet. Response: all 3 payload beats still carry the overlay; the next packet is bypassed.
- Backpressure. Stimulus: m_axis_tready=0 for 10 cycles with a full FIFO. Response: s_axis_tready=0; output held stable; no beat lost or duplicated; order preserved.
- Metadata-only packet. Stimulus: a 1-beat packet with tlast=1, em_enable=1. Response: no output; drop_count=1; the next packet is processed normally.
- Reset mid-packet. Stimulus: sw_rst pulsed, or axi_aresetn asserted, mid-packet. Response: counters 0; the next accepted beat is treated as metadata.
